// File: rtl/dmem_responder.sv
// Data-memory responder on the LSU request/response interface: byte-strobed stores,
// word loads with a fixed response latency, and one load in flight at a time.
module dmem_responder #(
    parameter int          ADDR_WIDTH   = 10,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_rvld,
    output logic        mem_err,
    output logic        load_busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int          DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [32:0] SPAN     = 33'd4 << ADDR_WIDTH;
    localparam logic [2:0]  CNT_INIT = 3'(READ_LATENCY - 1);

    logic [31:0]           mem_q [0:DEPTH-1];

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  rvld_q, rvld_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           resp_q, resp_d;
    logic                  resp_err_q, resp_err_d;

    logic [31:0]           off_s;
    logic                  in_range_s;
    logic [ADDR_WIDTH-1:0] idx_s;
    logic                  accept_s;
    logic                  viol_s;
    logic                  acc_load_s;
    logic                  acc_store_s;
    logic [31:0]           rd_word_s;

    // Address decode, range check and request classification.
    always_comb begin
        off_s       = mem_addr - BASE_ADDR;
        in_range_s  = ({1'b0, off_s} < SPAN);
        idx_s       = off_s[ADDR_WIDTH+1:2];
        accept_s    = mem_en & (~busy_q | rvld_q);
        viol_s      = mem_en & busy_q & ~rvld_q;
        acc_load_s  = accept_s & (mem_wen == 4'b0000);
        acc_store_s = accept_s & (mem_wen != 4'b0000);
        if (in_range_s) begin
            rd_word_s = mem_q[idx_s];
        end else begin
            rd_word_s = 32'h0000_0000;
        end
    end

    // Next-state logic for the load tracker and all registered outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        resp_d     = resp_q;
        resp_err_d = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (acc_load_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else if (acc_load_s) begin
                    cnt_d = CNT_INIT;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase

        if (acc_load_s) begin
            resp_d     = rd_word_s;
            resp_err_d = ~in_range_s;
        end else begin
            resp_d     = resp_q;
            resp_err_d = resp_err_q;
        end

        // resp_d already holds the fresh word when the response is due next cycle.
        rvld_d = (state_d == ST_WAIT) && (cnt_d == 3'd0);
        busy_d = (state_d == ST_WAIT);
        if (rvld_d) begin
            rdata_d = resp_d;
        end else begin
            rdata_d = rdata_q;
        end
        err_d = viol_s | (acc_store_s & ~in_range_s) | (rvld_d & resp_err_d);
    end

    // Control and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            rvld_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0000_0000;
            resp_q     <= 32'h0000_0000;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rvld_q     <= rvld_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            resp_q     <= resp_d;
            resp_err_q <= resp_err_d;
        end
    end

    // Data array: byte-lane writes, contents survive reset.
    always_ff @(posedge CLK) begin
        if (acc_store_s && in_range_s) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wen[i]) begin
                    mem_q[idx_s][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_rvld  = rvld_q;
    assign mem_err   = err_q;
    assign load_busy = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (latency 1, 3, 4) checked against a
// timestamped transaction model plus directed scenarios with fixed expected words.
module tb_dmem_responder;

    localparam int          AW   = 6;
    localparam int          NW   = 64;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        en    [3];
    logic [3:0]  wen   [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        rvld  [3];
    logic        err   [3];
    logic        busy  [3];

    logic [31:0] mmem [3][NW];
    bit          pv    [3];
    int          pdue  [3];
    logic [31:0] pdata [3];
    bit          perr  [3];
    int          cyc_n = 0;
    logic        exp_rvld  [3];
    logic        exp_err   [3];
    logic        exp_busy  [3];
    logic [31:0] exp_rdata [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .READ_LATENCY(1)) u_l1 (
        .CLK(clk), .RST(rst), .mem_en(en[0]), .mem_wen(wen[0]), .mem_addr(addr[0]),
        .mem_wdata(wdata[0]), .mem_rdata(rdata[0]), .mem_rvld(rvld[0]), .mem_err(err[0]),
        .load_busy(busy[0]));
    dmem_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .READ_LATENCY(3)) u_l3 (
        .CLK(clk), .RST(rst), .mem_en(en[1]), .mem_wen(wen[1]), .mem_addr(addr[1]),
        .mem_wdata(wdata[1]), .mem_rdata(rdata[1]), .mem_rvld(rvld[1]), .mem_err(err[1]),
        .load_busy(busy[1]));
    dmem_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .READ_LATENCY(4)) u_l4 (
        .CLK(clk), .RST(rst), .mem_en(en[2]), .mem_wen(wen[2]), .mem_addr(addr[2]),
        .mem_wdata(wdata[2]), .mem_rdata(rdata[2]), .mem_rvld(rvld[2]), .mem_err(err[2]),
        .load_busy(busy[2]));

    function automatic int rl_of(input int k);
        if (k == 0) return 1;
        else if (k == 1) return 3;
        else return 4;
    endfunction

    task automatic idle_inputs();
        for (int j = 0; j < 3; j++) begin
            en[j] = 1'b0; wen[j] = 4'h0; addr[j] = 32'h0; wdata[j] = 32'h0;
        end
    endtask

    task automatic req(input int k, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en[k] = 1'b1; wen[k] = w; addr[k] = a; wdata[k] = d;
    endtask

    // One clock: the model sees the same inputs as the DUTs, then outputs settle.
    task automatic step();
        logic [31:0] off;
        bit          inr, busy_now, rv_now;
        int          idx;
        bit          errn [3];
        @(posedge clk);
        for (int j = 0; j < 3; j++) begin
            busy_now = pv[j];
            rv_now   = pv[j] && (pdue[j] == cyc_n);
            errn[j]  = 1'b0;
            if (rv_now) pv[j] = 1'b0;
            if (en[j]) begin
                off = addr[j] - BASE;
                inr = (off < 32'(4 * NW));
                idx = int'(off[AW+1:2]);
                if (busy_now && !rv_now) begin
                    errn[j] = 1'b1;
                end else if (wen[j] != 4'h0) begin
                    if (inr) begin
                        for (int b = 0; b < 4; b++)
                            if (wen[j][b]) mmem[j][idx][8*b +: 8] = wdata[j][8*b +: 8];
                    end else begin
                        errn[j] = 1'b1;
                    end
                end else begin
                    pv[j]    = 1'b1;
                    pdue[j]  = cyc_n + rl_of(j);
                    pdata[j] = inr ? mmem[j][idx] : 32'h0;
                    perr[j]  = !inr;
                end
            end
        end
        cyc_n++;
        for (int j = 0; j < 3; j++) begin
            exp_busy[j] = pv[j];
            exp_rvld[j] = pv[j] && (pdue[j] == cyc_n);
            if (exp_rvld[j]) exp_rdata[j] = pdata[j];
            exp_err[j]  = errn[j] | (exp_rvld[j] & perr[j]);
        end
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        for (int j = 0; j < 3; j++) begin
            pv[j] = 1'b0; exp_rvld[j] = 1'b0; exp_err[j] = 1'b0;
            exp_busy[j] = 1'b0; exp_rdata[j] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({rvld[k], err[k], busy[k], rdata[k]} !== 35'h0) begin
                bad++;
                $display("FAIL reset_outputs inst=%0d got rvld=%b err=%b busy=%b rdata=%h want all 0",
                         k, rvld[k], err[k], busy[k], rdata[k]);
            end
        end
    endtask

    task automatic preload();
        for (int k = 0; k < 3; k++)
            for (int w = 0; w < NW; w++) begin
                req(k, 4'hF, BASE + 32'(4 * w), $urandom);
                step();
            end
    endtask

    task automatic test_basic();
        req(0, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF); step();
        total++;
        if (rvld[0] !== 1'b0 || err[0] !== 1'b0) begin
            bad++; $display("FAIL store_no_resp got rvld=%b err=%b want 0 0", rvld[0], err[0]);
        end
        req(0, 4'h0, BASE + 32'h10, 32'h0); step();
        total++;
        if (rvld[0] !== 1'b1 || rdata[0] !== 32'hDEAD_BEEF || err[0] !== 1'b0) begin
            bad++; $display("FAIL basic_load got rvld=%b rdata=%h err=%b want 1 deadbeef 0",
                            rvld[0], rdata[0], err[0]);
        end
        step();
        total++;
        if (rvld[0] !== 1'b0 || busy[0] !== 1'b0 || rdata[0] !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL basic_hold got rvld=%b busy=%b rdata=%h want 0 0 deadbeef",
                            rvld[0], busy[0], rdata[0]);
        end
    endtask

    task automatic test_byte_strobe();
        req(0, 4'hF, BASE + 32'h10, 32'h1122_3344); step();
        req(0, 4'b0100, BASE + 32'h12, 32'h00AB_0000); step();
        req(0, 4'h0, BASE + 32'h10, 32'h0); step();
        total++;
        if (rvld[0] !== 1'b1 || rdata[0] !== 32'h11AB_3344) begin
            bad++; $display("FAIL byte_store got rvld=%b rdata=%h want 1 11ab3344", rvld[0], rdata[0]);
        end
        req(0, 4'b1100, BASE + 32'h10, 32'hCAFE_0000); step();
        req(0, 4'h0, BASE + 32'h10, 32'h0); step();
        total++;
        if (rvld[0] !== 1'b1 || rdata[0] !== 32'hCAFE_3344) begin
            bad++; $display("FAIL half_store got rvld=%b rdata=%h want 1 cafe3344", rvld[0], rdata[0]);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            req(0, 4'hF, BASE + 32'(8 * i), 32'hA000_0000 + 32'(i)); step();
        end
        for (int i = 0; i < 4; i++) begin
            req(0, 4'h0, BASE + 32'(8 * i), 32'h0); step();
            total++;
            if (rvld[0] !== 1'b1 || busy[0] !== 1'b1 || rdata[0] !== 32'hA000_0000 + 32'(i)) begin
                bad++; $display("FAIL b2b_l1 i=%0d got rvld=%b busy=%b rdata=%h want 1 1 %h",
                                i, rvld[0], busy[0], rdata[0], 32'hA000_0000 + 32'(i));
            end
        end
        req(1, 4'hF, BASE + 32'h40, 32'h0101_A5A5); step();
        req(1, 4'hF, BASE + 32'h44, 32'h7E7E_0001); step();
        req(1, 4'h0, BASE + 32'h40, 32'h0); step();
        for (int c = 1; c <= 6; c++) begin
            total++;
            if (busy[1] !== 1'b1 || rvld[1] !== (c == 3 || c == 6) || err[1] !== 1'b0) begin
                bad++; $display("FAIL b2b_l3 c=%0d got busy=%b rvld=%b err=%b", c, busy[1], rvld[1], err[1]);
            end
            if (c == 3) begin
                total++;
                if (rdata[1] !== 32'h0101_A5A5) begin
                    bad++; $display("FAIL b2b_l3_d0 got %h want 0101a5a5", rdata[1]);
                end
                req(1, 4'h0, BASE + 32'h44, 32'h0);
            end
            if (c == 6) begin
                total++;
                if (rdata[1] !== 32'h7E7E_0001) begin
                    bad++; $display("FAIL b2b_l3_d1 got %h want 7e7e0001", rdata[1]);
                end
            end
            step();
        end
        total++;
        if (busy[1] !== 1'b0 || rvld[1] !== 1'b0) begin
            bad++; $display("FAIL b2b_l3_end got busy=%b rvld=%b want 0 0", busy[1], rvld[1]);
        end
    endtask

    task automatic test_out_of_range();
        req(0, 4'hF, BASE, 32'h600D_F00D); step();
        req(0, 4'h0, BASE + 32'h100, 32'h0); step();
        total++;
        if (rvld[0] !== 1'b1 || rdata[0] !== 32'h0 || err[0] !== 1'b1) begin
            bad++; $display("FAIL oor_load got rvld=%b rdata=%h err=%b want 1 0 1", rvld[0], rdata[0], err[0]);
        end
        req(0, 4'h0, BASE - 32'h4, 32'h0); step();
        total++;
        if (rvld[0] !== 1'b1 || rdata[0] !== 32'h0 || err[0] !== 1'b1) begin
            bad++; $display("FAIL oor_low got rvld=%b rdata=%h err=%b want 1 0 1", rvld[0], rdata[0], err[0]);
        end
        req(0, 4'hF, BASE + 32'h100, 32'hBAD0_BAD0); step();
        total++;
        if (err[0] !== 1'b1 || rvld[0] !== 1'b0) begin
            bad++; $display("FAIL oor_store got err=%b rvld=%b want 1 0", err[0], rvld[0]);
        end
        req(0, 4'h0, BASE, 32'h0); step();
        total++;
        if (err[0] !== 1'b0 || rdata[0] !== 32'h600D_F00D) begin
            bad++; $display("FAIL oor_nowrite got err=%b rdata=%h want 0 600df00d", err[0], rdata[0]);
        end
    endtask

    task automatic test_violation();
        int npulse;
        req(2, 4'hF, BASE + 32'h20, 32'h55AA_55AA); step();
        req(2, 4'hF, BASE + 32'h24, 32'h1234_5678); step();
        req(2, 4'h0, BASE + 32'h20, 32'h0); step();
        req(2, 4'hF, BASE + 32'h24, 32'hFFFF_FFFF); step();
        npulse = 0;
        for (int c = 2; c <= 4; c++) begin
            if (err[2] === 1'b1) npulse++;
            total++;
            if (busy[2] !== 1'b1 || rvld[2] !== (c == 4)) begin
                bad++; $display("FAIL viol_busy c=%0d got busy=%b rvld=%b", c, busy[2], rvld[2]);
            end
            if (c < 4) step();
        end
        total++;
        if (npulse != 1 || rdata[2] !== 32'h55AA_55AA) begin
            bad++; $display("FAIL viol_pulse got pulses=%0d rdata=%h want 1 55aa55aa", npulse, rdata[2]);
        end
        step();
        req(2, 4'h0, BASE + 32'h24, 32'h0);
        repeat (4) step();
        total++;
        if (rvld[2] !== 1'b1 || rdata[2] !== 32'h1234_5678) begin
            bad++; $display("FAIL viol_dropped got rvld=%b rdata=%h want 1 12345678", rvld[2], rdata[2]);
        end
    endtask

    task automatic test_reset_mid_load();
        req(2, 4'h0, BASE + 32'h20, 32'h0); step();
        step();
        rst = 1'b1;
        #2;
        total++;
        if ({rvld[2], err[2], busy[2], rdata[2]} !== 35'h0) begin
            bad++; $display("FAIL mid_reset got rvld=%b err=%b busy=%b rdata=%h want all 0",
                            rvld[2], err[2], busy[2], rdata[2]);
        end
        do_reset();
        for (int c = 0; c < 8; c++) begin
            step();
            total++;
            if (rvld[2] !== 1'b0 || busy[2] !== 1'b0) begin
                bad++; $display("FAIL mid_reset_after c=%0d got rvld=%b busy=%b want 0 0", c, rvld[2], busy[2]);
            end
        end
    endtask

    task automatic test_random();
        int r;
        logic [31:0] a;
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 9) < 6) begin
                    r = $urandom_range(0, 11);
                    if (r == 0) a = BASE + 32'h100 + 32'($urandom_range(0, 255));
                    else if (r == 1) a = BASE - 32'($urandom_range(1, 16));
                    else a = BASE + 32'($urandom_range(0, 255));
                    if ($urandom_range(0, 1) == 0) req(k, 4'h0, a, 32'h0);
                    else req(k, 4'($urandom_range(1, 15)), a, $urandom);
                end
            end
            step();
            for (int k = 0; k < 3; k++) begin
                total++;
                if ({rvld[k], err[k], busy[k], rdata[k]} !==
                    {exp_rvld[k], exp_err[k], exp_busy[k], exp_rdata[k]}) begin
                    bad++;
                    $display("FAIL random n=%0d inst=%0d got rvld=%b err=%b busy=%b rdata=%h want %b %b %b %h",
                             n, k, rvld[k], err[k], busy[k], rdata[k],
                             exp_rvld[k], exp_err[k], exp_busy[k], exp_rdata[k]);
                end
            end
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        preload();
        test_basic();
        test_byte_strobe();
        test_back_to_back();
        test_out_of_range();
        test_violation();
        test_reset_mid_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
